// File: rtl/huff_pkg.sv
`default_nettype none
// ============================================================================
// Module   : huff_pkg
// Brief    : Shared sizes, table entry type, state encoding and table word
//            field positions for the Huffman bit packer.
// Revision : 1.0 - initial release
// ============================================================================
package huff_pkg;

    parameter int MAX_CHAR_COUNT = 3;
    parameter int CODE_W         = 3;
    parameter int LEN_W          = $clog2(CODE_W + 1);

    // 9-bit table word layout: [8]=valid, [7:0]=payload
    localparam int c_tw_valid_bit = 8;
    localparam int c_tw_char_msb  = 7;
    localparam int c_tw_mask_msb  = 5;
    localparam int c_tw_mask_lsb  = 3;
    localparam int c_tw_value_msb = 2;

    typedef struct packed {
        logic [7:0]        ch;
        logic [CODE_W-1:0] mask;
        logic [CODE_W-1:0] value;
    } tbl_entry_t;

    typedef enum logic [1:0] {
        LOAD_CHAR = 2'd0,
        LOAD_CODE = 2'd1,
        ENCODE    = 2'd2,
        FLUSH     = 2'd3
    } state_t;

    function automatic logic [LEN_W-1:0] popcount(input logic [CODE_W-1:0] v);
        logic [LEN_W-1:0] n;
        n = '0;
        for (int i = 0; i < CODE_W; i++) begin
            n = n + LEN_W'(v[i]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/huff_code_lookup.sv
`default_nettype none
// ============================================================================
// Module   : huff_code_lookup
// Brief    : Combinational symbol-to-code match; lowest table index wins.
// Revision : 1.0 - initial release
// ============================================================================
module huff_code_lookup
    import huff_pkg::*;
(
    input  logic [7:0]        i_sym,
    input  tbl_entry_t        i_table [MAX_CHAR_COUNT],
    output logic              o_hit,
    output logic [LEN_W-1:0]  o_len,
    output logic [CODE_W-1:0] o_value
);

    // Scanning from the top down lets the lowest matching index overwrite last.
    always_comb begin
        o_hit   = 1'b0;
        o_len   = '0;
        o_value = '0;
        for (int i = MAX_CHAR_COUNT - 1; i >= 0; i--) begin
            if (i_table[i].ch == i_sym) begin
                o_hit   = 1'b1;
                o_len   = popcount(i_table[i].mask);
                o_value = i_table[i].value & i_table[i].mask;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/huff_bitpacker.sv
`default_nettype none
// ============================================================================
// Module   : huff_bitpacker
// Brief    : Loads a Huffman code table from the encoder stream, then packs
//            symbol codes MSB-first into bytes with flush/padding support.
// Revision : 1.0 - initial release
// ============================================================================
module huff_bitpacker
    import huff_pkg::*;
#(
    parameter int BUF_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] tbl_in,
    input  logic       sym_valid,
    input  logic [7:0] sym_in,
    output logic       sym_ready,
    input  logic       flush,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    input  logic       byte_ready,
    output logic       table_loaded,
    output logic       err_unknown,
    output logic       flush_done
);

    localparam int c_cnt_w = $clog2(BUF_W + 1);
    localparam int c_k_w   = $clog2(MAX_CHAR_COUNT + 1);
    localparam logic [c_cnt_w-1:0] c_byte_bits = c_cnt_w'(8);
    localparam logic [c_k_w-1:0]   c_last_k    = c_k_w'(MAX_CHAR_COUNT - 1);

    state_t              r_state;
    state_t              w_state_next;
    tbl_entry_t          r_tbl [MAX_CHAR_COUNT];
    logic [c_k_w-1:0]    r_k;
    logic                r_loaded;
    logic [BUF_W-1:0]    r_acc;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_err;

    logic                w_tbl_valid;
    logic                w_sym_ready;
    logic                w_byte_valid;
    logic                w_accept;
    logic                w_take;
    logic                w_append;
    logic                w_hit;
    logic [LEN_W-1:0]    w_len;
    logic [CODE_W-1:0]   w_value;
    logic [BUF_W-1:0]    w_acc_shift;
    logic [BUF_W-1:0]    w_acc_next;
    logic [BUF_W-1:0]    w_code_top;
    logic [c_cnt_w-1:0]  w_cnt_shift;
    logic [c_cnt_w-1:0]  w_cnt_next;

    huff_code_lookup u_lookup (
        .i_sym   (sym_in),
        .i_table (r_tbl),
        .o_hit   (w_hit),
        .o_len   (w_len),
        .o_value (w_value)
    );

    assign w_tbl_valid  = tbl_in[c_tw_valid_bit];
    assign w_sym_ready  = (r_state == ENCODE) && (r_count < c_byte_bits) && !flush;
    assign w_byte_valid = (r_count >= c_byte_bits) || ((r_state == FLUSH) && (r_count != '0));
    assign w_accept     = sym_valid && w_sym_ready;
    assign w_take       = w_byte_valid && byte_ready;
    assign w_append     = w_accept && w_hit;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LOAD_CHAR: if (w_tbl_valid) w_state_next = LOAD_CODE;
            LOAD_CODE: if (w_tbl_valid) w_state_next = (r_k == c_last_k) ? ENCODE : LOAD_CHAR;
            ENCODE:    if (flush) w_state_next = FLUSH;
            FLUSH:     if (r_count == '0) w_state_next = ENCODE;
            default:   w_state_next = LOAD_CHAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= LOAD_CHAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
                r_tbl[i] <= '0;
            end
            r_k      <= '0;
            r_loaded <= 1'b0;
        end else begin
            if ((r_state == LOAD_CHAR) && w_tbl_valid) begin
                r_tbl[r_k].ch <= tbl_in[c_tw_char_msb:0];
            end
            if ((r_state == LOAD_CODE) && w_tbl_valid) begin
                r_tbl[r_k].mask  <= tbl_in[c_tw_mask_msb:c_tw_mask_lsb];
                r_tbl[r_k].value <= tbl_in[c_tw_value_msb:0];
                r_k              <= r_k + 1'b1;
                if (r_k == c_last_k) begin
                    r_loaded <= 1'b1;
                end
            end
        end
    end

    // Drain first, then append the new code right after the surviving bits.
    always_comb begin
        w_acc_shift = r_acc;
        w_cnt_shift = r_count;
        if (w_take) begin
            w_acc_shift = r_acc << 8;
            w_cnt_shift = (r_count >= c_byte_bits) ? (r_count - c_byte_bits) : '0;
        end
        w_code_top = BUF_W'(w_value) << (c_cnt_w'(BUF_W) - c_cnt_w'(w_len));
        w_acc_next = w_acc_shift;
        w_cnt_next = w_cnt_shift;
        if (w_append) begin
            w_acc_next = w_acc_shift | (w_code_top >> w_cnt_shift);
            w_cnt_next = w_cnt_shift + c_cnt_w'(w_len);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_acc   <= w_acc_next;
            r_count <= w_cnt_next;
            r_err   <= w_accept && !w_hit;
        end
    end

    assign sym_ready    = w_sym_ready;
    assign byte_valid   = w_byte_valid;
    assign byte_out     = r_acc[BUF_W-1 -: 8];
    assign table_loaded = r_loaded;
    assign err_unknown  = r_err;
    assign flush_done   = (r_state == FLUSH) && (r_count == '0);

endmodule
`default_nettype wire

// File: doc/huff_bitpacker.md
Name: huff_bitpacker

Overview:
- Downstream consumer of huff_encoder. Captures the code table from the encoder's 9-bit output stream: a character word followed by its code word, once per character.
- Once the table is loaded, maps an incoming symbol byte stream to variable-length codes.
- Packs the codes MSB-first into bytes and emits them on a valid/ready interface.
- A flush pads and drains the final partial byte.

Parameters:
- MAX_CHAR_COUNT, 3, number of table entries; the load phase takes 2*MAX_CHAR_COUNT words.
- CODE_W, 3, width of the code value and mask fields; equals MAX_CHAR_COUNT.
- BUF_W, 16, bit-accumulator width; must be at least 8+CODE_W.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- tbl_in  in  9  encoder output word: [8]=valid, [7:0]=payload.
- sym_valid  in  1  symbol offered.
- sym_in  in  8  symbol character.
- sym_ready  out  1  symbol accepted when sym_valid && sym_ready.
- flush  in  1  single-cycle request to drain the partial byte.
- byte_valid  out  1  packed byte available.
- byte_out  out  8  packed byte, first code bit in [7].
- byte_ready  in  1  downstream accepts the byte when byte_valid && byte_ready.
- table_loaded  out  1  table complete, encoding enabled.
- err_unknown  out  1  one-cycle pulse: an accepted symbol is not in the table.
- flush_done  out  1  one-cycle pulse: flush finished and accumulator is empty.

Behaviour:
- Reset (async, reset=0) clears:
  - all table entries and the word counter;
  - accumulator and bit count to 0;
  - state to LOAD_CHAR;
  - all outputs to 0.
- Reset asserted mid-load or mid-encode discards all table and buffered data. No partial byte is emitted.
- Table word format:
  - Character word: payload = 8-bit char.
  - Code word: payload[7:6]=0, [5:3]=mask, [2:0]=value.
  - Code length = popcount(mask). The mask must be contiguous from bit 0.
  - Code bits are value[len-1:0], emitted MSB-first.
- State LOAD_CHAR:
  - On tbl_in[8]=1, store char[k], where k = entry index, then go to LOAD_CODE.
  - Words with [8]=0 are ignored.
- State LOAD_CODE:
  - On tbl_in[8]=1, store mask[k] and value[k], then increment k.
  - If k reaches MAX_CHAR_COUNT, go to ENCODE and set table_loaded=1. Otherwise return to LOAD_CHAR.
- State ENCODE:
  - sym_ready = (bit count < 8) && !flush.
  - On accept, look up sym_in against char[0..MAX_CHAR_COUNT-1]. Lowest index wins on duplicates.
  - Match: append len bits at accumulator position (count). count += len.
  - Mask 000 (single-character table): the symbol is accepted and produces 0 bits, with no error.
  - No match: symbol consumed, no bits appended, err_unknown pulses in the next cycle.
- Byte output:
  - byte_valid = registered (count >= 8), or FLUSH state with count > 0.
  - byte_out = accumulator top 8 bits. In FLUSH with count < 8, the unused LSBs are 0.
  - On handshake, shift the accumulator left 8 and set count = max(count-8, 0).
  - byte_out and byte_valid stay stable while byte_ready=0.
- Simultaneous symbol accept and byte handshake in one cycle: count_next = count - 8 + len. Both take effect.
- Latency: a symbol that completes a byte in cycle N gives byte_valid=1 in cycle N+1.
- Table words arriving while table_loaded=1 are ignored. A new table requires reset.
- flush:
  - Sampled only in ENCODE; ignored otherwise.
  - ENCODE -> FLUSH. sym_ready=0 in FLUSH.
  - Emit full bytes, then one padded partial byte.
  - When count=0, pulse flush_done and return to ENCODE.
  - A flush with count=0 pulses flush_done the next cycle with no byte emitted.
- Invariant: count <= 8+CODE_W-1 at all times. No overflow is possible.

Decomposition:
- Shared package huff_pkg holds:
  - MAX_CHAR_COUNT and CODE_W;
  - table entry struct typedef {char[7:0], mask[CODE_W-1:0], value[CODE_W-1:0]};
  - state enum {LOAD_CHAR, LOAD_CODE, ENCODE, FLUSH};
  - 9-bit table word field positions.
- One sub-module: huff_code_lookup. Combinational match from sym_in to {hit, len, value}, including popcount and priority select.

Test Plan:
- Table load: feed words 0x161, 0x109, 0x16E, 0x118, 0x16D, 0x119 -> table_loaded=1 after the 6th word. Lookups give a=1, n=00, m=01.
- Partial byte: symbols "anma" then flush -> bits 100011 -> byte_out=0x8C, then flush_done pulses.
- Byte boundary crossing: symbols "nnnna" (9 bits) -> byte 0x00 emitted without flush; flush -> 0x80.
- Backpressure: "aaaaaaaaaa" with byte_ready=0 -> byte_valid=1 with byte_out=0xFF held stable. sym_ready=0 once count>=8. Release byte_ready -> 0xFF accepted, then flush -> 0xC0.
- Unknown symbol and single-char table: sym_in='x' -> err_unknown pulses, no bits added. Table with mask 000 -> symbols accepted, no bytes, flush_done with no byte.
- Reset mid-operation: drop reset to 0 with count=5 and state ENCODE -> all outputs 0 immediately, table_loaded=0. After release the block requires a full table reload.
